// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: bus request and
// response layouts, the F/D hand-off record, FSM state encodings and the
// next-pc select codes used by the pc mux.
package fetch_unit_pkg;

    localparam logic [63:0] PC_RESET = 64'h8000_0000;
    localparam logic [63:0] PC_STEP  = 64'd4;

    // Instruction bus request: valid and addr are held until data_ok.
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // Record presented to the F/D pipeline register.
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_data_t;

    // Instruction parked while the F/D register stalls.
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_buf_t;

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_REQ  = 1'b0;
    localparam fetch_state_t ST_HOLD = 1'b1;

    typedef enum logic [1:0] {
        PCS_HOLD  = 2'd0,
        PCS_STEP  = 2'd1,
        PCS_REDIR = 2'd2,
        PCS_TGT   = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pcselect.sv
// Combinational next-pc mux: keep, step sequentially, take the live redirect
// target, or take the target remembered while a request was in flight.
module fetch_unit_pcselect
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] STEP = PC_STEP
) (
    input  pc_sel_t     sel_i,
    input  logic [63:0] pc_i,
    input  logic [63:0] redir_i,
    input  logic [63:0] tgt_i,
    output logic [63:0] pc_nxt_o
);

    // Arithmetic is modulo 2^64, so the top of the address space wraps to 0.
    always_comb begin
        pc_nxt_o = pc_i;
        case (sel_i)
            PCS_HOLD:  pc_nxt_o = pc_i;
            PCS_STEP:  pc_nxt_o = pc_i + STEP;
            PCS_REDIR: pc_nxt_o = redir_i;
            PCS_TGT:   pc_nxt_o = tgt_i;
            default:   pc_nxt_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage. Owns the fetch pc, issues one instruction read at a time and hands
// the result to the F/D register.
// Handshake: the bus request (valid, addr) is held unchanged until data_ok;
// a hand-off to F/D happens in a cycle where dataF_nxt.valid=1 and out_ready=1.
// Redirects seen while a read is in flight are remembered and applied when
// that read completes; the stale instruction is dropped.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET,
    parameter logic [63:0] STEP_PC  = PC_STEP
) (
    input  logic         clk,
    input  logic         reset,
    output ibus_req_t    ireq,
    input  ibus_resp_t   iresp,
    input  logic         PCSel,
    input  logic [63:0]  pc_address,
    input  logic         out_ready,
    output fetch_data_t  dataF_nxt,
    output logic [63:0]  last_pc,
    output fetch_state_t state_o
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  tgt_q, tgt_d;
    logic         discard_q, discard_d;
    fetch_buf_t   buf_q, buf_d;
    pc_sel_t      pc_sel;

    // addr_ok carries no information for a single-outstanding fetcher.
    logic unused_addr_ok;
    assign unused_addr_ok = iresp.addr_ok;

    fetch_unit_pcselect #(.STEP(STEP_PC)) u_pcselect (
        .sel_i    (pc_sel),
        .pc_i     (pc_q),
        .redir_i  (pc_address),
        .tgt_i    (tgt_q),
        .pc_nxt_o (pc_d)
    );

    // FSM next state, bus request and F/D output. Priority PCSel > data_ok > out_ready.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        discard_d = discard_q;
        buf_d     = buf_q;
        pc_sel    = PCS_HOLD;
        ireq      = '0;
        dataF_nxt = '0;
        case (state_q)
            ST_REQ: begin
                ireq.valid = 1'b1;
                ireq.addr  = pc_q;
                if (iresp.data_ok) begin
                    if (PCSel) begin
                        pc_sel    = PCS_REDIR;
                        discard_d = 1'b0;
                    end else if (discard_q) begin
                        pc_sel    = PCS_TGT;
                        discard_d = 1'b0;
                    end else if (out_ready) begin
                        dataF_nxt = '{raw_instr: iresp.data, pc: pc_q, valid: 1'b1};
                        pc_sel    = PCS_STEP;
                    end else begin
                        buf_d   = '{raw_instr: iresp.data, pc: pc_q};
                        state_d = ST_HOLD;
                    end
                end else if (PCSel) begin
                    discard_d = 1'b1;
                    tgt_d     = pc_address;
                end
            end
            ST_HOLD: begin
                if (PCSel) begin
                    pc_sel  = PCS_REDIR;
                    state_d = ST_REQ;
                end else begin
                    dataF_nxt = '{raw_instr: buf_q.raw_instr, pc: buf_q.pc, valid: 1'b1};
                    if (out_ready) begin
                        pc_sel  = PCS_STEP;
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_REQ;
        endcase
        // The bus slave is reset alongside us, so nothing is requested or handed off.
        if (reset) begin
            ireq.valid      = 1'b0;
            dataF_nxt.valid = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            tgt_q     <= '0;
            discard_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            discard_q <= discard_d;
            buf_q     <= buf_d;
        end
    end

    assign last_pc = pc_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk;
    logic         reset;
    ibus_req_t    ireq;
    ibus_resp_t   iresp;
    logic         PCSel;
    logic [63:0]  pc_address;
    logic         out_ready;
    fetch_data_t  dataF_nxt;
    logic [63:0]  last_pc;
    fetch_state_t state_o;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ireq       (ireq),
        .iresp      (iresp),
        .PCSel      (PCSel),
        .pc_address (pc_address),
        .out_ready  (out_ready),
        .dataF_nxt  (dataF_nxt),
        .last_pc    (last_pc),
        .state_o    (state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iresp = '0;
        PCSel = 1'b0;
        out_ready = 1'b1;
        adv();
        reset = 1'b0;
    endtask

    task automatic chk_addr(input string name, input logic [63:0] exp);
        checks++;
        if (ireq.valid !== 1'b1 || ireq.addr !== exp) begin
            errors++;
            $display("FAIL %s: ireq valid=%0b addr=%h, required valid=1 addr=%h",
                     name, ireq.valid, ireq.addr, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [63:0] pc,
                           input logic [31:0] ins);
        checks++;
        if (dataF_nxt.valid !== v || (v && (dataF_nxt.pc !== pc || dataF_nxt.raw_instr !== ins))) begin
            errors++;
            $display("FAIL %s: out valid=%0b pc=%h instr=%h, required valid=%0b pc=%h instr=%h",
                     name, dataF_nxt.valid, dataF_nxt.pc, dataF_nxt.raw_instr, v, pc, ins);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; iresp = '0; PCSel = 1'b0; pc_address = '0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ireq.valid !== 1'b0 || dataF_nxt.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: ireq.valid=%0b out.valid=%0b, required 0/0",
                     ireq.valid, dataF_nxt.valid);
        end
        checks++;
        if (last_pc !== 64'h8000_0000 || state_o !== ST_REQ) begin
            errors++;
            $display("FAIL reset_pc: last_pc=%h state=%0d, required 80000000/REQ", last_pc, state_o);
        end
        adv();
        reset = 1'b0;
        @(negedge clk);
        chk_addr("reset_first_addr", 64'h8000_0000);
        adv();
    endtask

    // 1-cycle bus: data_ok arrives in the request's first cycle.
    task automatic test_sequential();
        logic [63:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 64'h8000_0000 + 64'(4 * i);
            iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(a)};
            @(negedge clk);
            chk_addr("seq_addr", a);
            chk_out("seq_out", 1'b1, a, instr_of(a));
            adv();
        end
        iresp = '0;
        @(negedge clk);
        chk_addr("seq_next", 64'h8000_0010);
        adv();
    endtask

    // 3-cycle bus with a redirect in the second wait cycle.
    task automatic test_redirect_wait();
        do_reset();
        iresp = '0;
        @(negedge clk);
        chk_addr("rw_wait1", 64'h8000_0000);
        adv();
        PCSel = 1'b1; pc_address = 64'h8000_0100;
        @(negedge clk);
        chk_addr("rw_wait2", 64'h8000_0000);
        chk_out("rw_wait2_out", 1'b0, '0, '0);
        adv();
        PCSel = 1'b0;
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'h8000_0000)};
        @(negedge clk);
        chk_addr("rw_dataok_addr", 64'h8000_0000);
        chk_out("rw_dropped", 1'b0, '0, '0);
        adv();
        iresp = '0;
        @(negedge clk);
        chk_addr("rw_new_addr", 64'h8000_0100);
        adv();
    endtask

    // Stall with out_ready=0, then release. Starts fetching at 8000_0100.
    task automatic test_hold();
        out_ready = 1'b0;
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'h8000_0100)};
        @(negedge clk);
        chk_addr("hold_capture_addr", 64'h8000_0100);
        adv();
        for (int i = 0; i < 4; i++) begin
            iresp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'hDEAD_0000 + 32'(i)};
            @(negedge clk);
            checks++;
            if (ireq.valid !== 1'b0 || state_o !== ST_HOLD) begin
                errors++;
                $display("FAIL hold_idle: ireq.valid=%0b state=%0d, required 0/HOLD", ireq.valid, state_o);
            end
            chk_out("hold_stable", 1'b1, 64'h8000_0100, instr_of(64'h8000_0100));
            adv();
        end
        out_ready = 1'b1;
        iresp = '0;
        @(negedge clk);
        chk_out("hold_release", 1'b1, 64'h8000_0100, instr_of(64'h8000_0100));
        adv();
        @(negedge clk);
        chk_addr("hold_next_addr", 64'h8000_0104);
        chk_out("hold_next_out", 1'b0, '0, '0);
        adv();
    endtask

    // HOLD with a redirect drops the buffered entry. Starts at 8000_0104.
    task automatic test_hold_redirect();
        out_ready = 1'b0;
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'h8000_0104)};
        adv();
        iresp = '0;
        PCSel = 1'b1; pc_address = 64'h8000_0200;
        @(negedge clk);
        chk_out("hr_dropped", 1'b0, '0, '0);
        checks++;
        if (ireq.valid !== 1'b0) begin
            errors++;
            $display("FAIL hr_ireq_idle: ireq.valid=%0b, required 0", ireq.valid);
        end
        adv();
        PCSel = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk_addr("hr_new_addr", 64'h8000_0200);
        chk_out("hr_no_out", 1'b0, '0, '0);
        adv();
    endtask

    // Redirect coincident with data_ok, then two redirects before data_ok.
    task automatic test_same_cycle();
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'h8000_0200)};
        PCSel = 1'b1; pc_address = 64'h8000_0300;
        @(negedge clk);
        chk_out("sc_dropped", 1'b0, '0, '0);
        adv();
        iresp = '0;
        PCSel = 1'b1; pc_address = 64'h8000_0400;
        @(negedge clk);
        chk_addr("sc_new_addr", 64'h8000_0300);
        adv();
        pc_address = 64'h8000_0500;
        @(negedge clk);
        chk_addr("two_hold_addr", 64'h8000_0300);
        adv();
        PCSel = 1'b0;
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'h8000_0300)};
        @(negedge clk);
        chk_out("two_dropped", 1'b0, '0, '0);
        adv();
        iresp = '0;
        @(negedge clk);
        chk_addr("two_last_wins", 64'h8000_0500);
        adv();
    endtask

    // Wrap at the top of the address space, then reset mid-request.
    task automatic test_wrap_and_reset();
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'h8000_0500)};
        PCSel = 1'b1; pc_address = 64'hFFFF_FFFF_FFFF_FFFC;
        adv();
        PCSel = 1'b0;
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'hFFFF_FFFF_FFFF_FFFC)};
        @(negedge clk);
        chk_addr("wrap_top_addr", 64'hFFFF_FFFF_FFFF_FFFC);
        chk_out("wrap_top_out", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, instr_of(64'hFFFF_FFFF_FFFF_FFFC));
        adv();
        iresp = '0;
        @(negedge clk);
        chk_addr("wrap_zero", 64'h0);
        adv();
        // Leave a pending redirect so reset must also clear discard.
        PCSel = 1'b1; pc_address = 64'h8000_0700;
        adv();
        PCSel = 1'b0;
        reset = 1'b1;
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hBAD0_BAD0};
        @(negedge clk);
        checks++;
        if (ireq.valid !== 1'b0 || dataF_nxt.valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valids: ireq.valid=%0b out.valid=%0b, required 0/0",
                     ireq.valid, dataF_nxt.valid);
        end
        adv();
        reset = 1'b0;
        iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: instr_of(64'h8000_0000)};
        @(negedge clk);
        chk_addr("rst_mid_addr", 64'h8000_0000);
        chk_out("rst_mid_clean", 1'b1, 64'h8000_0000, instr_of(64'h8000_0000));
        adv();
        iresp = '0;
        @(negedge clk);
        chk_addr("rst_mid_step", 64'h8000_0004);
        adv();
    endtask

    initial begin
        reset = 1'b1; iresp = '0; PCSel = 1'b0; pc_address = '0; out_ready = 1'b1;
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_hold();
        test_hold_redirect();
        test_same_cycle();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
